// File: rtl/aes_inv_cipher_if.sv
// Request/response bundle for the AES-128 inverse cipher.
// master: start, ct_in, key10_in out; busy, pt_out, pt_valid in.
interface aes_inv_cipher_if;
    logic         start;
    logic [127:0] ct_in;
    logic [127:0] key10_in;
    logic         busy;
    logic [127:0] pt_out;
    logic         pt_valid;

    modport master (
        output start, ct_in, key10_in,
        input  busy, pt_out, pt_valid
    );

    modport slave (
        input  start, ct_in, key10_in,
        output busy, pt_out, pt_valid
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, keys regenerated backwards.
// Ports: clk, rst_n (sync, active-low), bus (slave: start/ct_in/key10_in -> busy/pt_out/pt_valid).

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] T [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign y = T[a];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] T [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
    assign y = T[a];
endmodule

module aes_inv_cipher (
    input  logic clk,
    input  logic rst_n,
    aes_inv_cipher_if.slave bus
);
    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, rk_q, pt_q;
    logic [3:0]   round_q;
    logic         pt_valid_q;
    logic         load, step, finish;

    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0]  sw_in, sw_out;
    logic [127:0] rk_prev, isr, isb, ark, imc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // round r consumes rcon[r+1] to step rk back one level
    always_comb begin
        rcon = 8'h00;
        unique case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w4 = rk_q[127:96];
    assign w5 = rk_q[95:64];
    assign w6 = rk_q[63:32];
    assign w7 = rk_q[31:0];
    assign w3 = w7 ^ w6;
    assign w2 = w6 ^ w5;
    assign w1 = w5 ^ w4;
    assign sw_in = {w3[23:0], w3[31:24]};
    assign w0 = w4 ^ sw_out ^ {rcon, 24'h0};
    assign rk_prev = {w0, w1, w2, w3};

    for (genvar i = 0; i < 4; i++) begin : g_fs
        aes_sbox u_sbox (
            .a(sw_in[31-8*i -: 8]),
            .y(sw_out[31-8*i -: 8])
        );
    end

    // byte (r,c) lives at index 4c+r; row r rotates right by r
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign isr[127-8*(4*c+r) -: 8] =
                state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_is
        aes_inv_sbox u_inv_sbox (
            .a(isr[127-8*i -: 8]),
            .y(isb[127-8*i -: 8])
        );
    end

    assign ark = isb ^ rk_prev;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];
        assign imc[127-32*c -: 8] =
            me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
        assign imc[119-32*c -: 8] =
            m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
        assign imc[111-32*c -: 8] =
            md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
        assign imc[103-32*c -: 8] =
            mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE: if (bus.start) fsm_d = RUN;
            RUN:  if (round_q == 4'd0) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (fsm_q)
            IDLE: load = bus.start;
            RUN: begin
                step   = (round_q != 4'd0);
                finish = (round_q == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= '0;
            rk_q       <= '0;
            round_q    <= '0;
            pt_q       <= '0;
            pt_valid_q <= 1'b0;
        end else begin
            pt_valid_q <= 1'b0;
            if (load) begin
                state_q <= bus.ct_in ^ bus.key10_in;
                rk_q    <= bus.key10_in;
                round_q <= 4'd9;
            end else if (step) begin
                state_q <= imc;
                rk_q    <= rk_prev;
                round_q <= round_q - 4'd1;
            end else if (finish) begin
                pt_q       <= ark;
                pt_valid_q <= 1'b1;
            end
        end
    end

    assign bus.busy     = (fsm_q == RUN);
    assign bus.pt_out   = pt_q;
    assign bus.pt_valid = pt_valid_q;
endmodule
